cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_run_monitor.sv | 145 ++++++++++++++
 tb/tb_cpu_run_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Watches a CPU run until timeout, halt PC, unknown PC or (optionally) a PC stall, then
// streams the register file out with a valid/ready handshake. Optional: RUN_MONITOR_STALL_DETECT_EN.
module cpu_run_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_REGS    = 32,
  parameter int unsigned     MAX_CYCLES  = 1000,
  parameter logic [XLEN-1:0] HALT_PC     = 'h100,
  parameter int unsigned     STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_unknown,
  input  logic [XLEN-1:0] reg_data,
  input  logic            dump_ready,
  output logic [4:0]      reg_sel,
  output logic            dump_valid,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            done,
  output logic [1:0]      done_cause,
  output logic [31:0]     cycle_count
);

  if (NUM_REGS < 1 || NUM_REGS > 32 || MAX_CYCLES < 1 || STALL_LIMIT < 1 || XLEN < 1) begin : g_bad_param
    $error("cpu_run_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd0;
  localparam logic [1:0]  CAUSE_HALT    = 2'd1;
  localparam logic [1:0]  CAUSE_UNKNOWN = 2'd2;
  localparam logic [1:0]  CAUSE_STALL   = 2'd3;
  localparam logic [4:0]  LAST_SEL      = 5'(NUM_REGS - 1);
  localparam logic [31:0] LAST_CYCLE    = 32'(MAX_CYCLES - 1);

  state_t      state_q;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [4:0]  reg_sel_q;
  logic        dump_valid_q;
  logic        done_q;
  logic [1:0]  done_cause_q, done_cause_d;
  logic        run_exit_d;
  logic        stall_hit;

`ifdef RUN_MONITOR_STALL_DETECT_EN
  logic [XLEN-1:0] last_pc_q;
  logic [31:0]     stall_cnt_q;
  logic            pc_match;

  assign pc_match  = pc_valid && (pc == last_pc_q);
  assign stall_hit = pc_match && (stall_cnt_q == 32'(STALL_LIMIT - 1));
`else
  assign stall_hit = 1'b0;
`endif

  // Termination cause priority: unknown PC, halt, stall, timeout.
  always_comb begin
    cycle_count_d = cycle_count_q + 32'd1;
    run_exit_d    = 1'b1;
    done_cause_d  = CAUSE_TIMEOUT;
    if (pc_valid && pc_unknown) begin
      done_cause_d = CAUSE_UNKNOWN;
    end else if (pc_valid && (pc == HALT_PC)) begin
      done_cause_d = CAUSE_HALT;
    end else if (stall_hit) begin
      done_cause_d = CAUSE_STALL;
    end else if (cycle_count_q == LAST_CYCLE) begin
      done_cause_d = CAUSE_TIMEOUT;
    end else begin
      run_exit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      cycle_count_q <= '0;
      reg_sel_q     <= '0;
      dump_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      done_cause_q  <= CAUSE_TIMEOUT;
`ifdef RUN_MONITOR_STALL_DETECT_EN
      last_pc_q     <= '0;
      stall_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          cycle_count_q <= cycle_count_d;
`ifdef RUN_MONITOR_STALL_DETECT_EN
          if (pc_match) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
          end else if (pc_valid) begin
            stall_cnt_q <= '0;
            last_pc_q   <= pc;
          end
`endif
          if (run_exit_d) begin
            state_q      <= S_DUMP;
            done_cause_q <= done_cause_d;
            dump_valid_q <= 1'b1;
            reg_sel_q    <= '0;
          end
        end
        S_DUMP: begin
          if (dump_valid_q && dump_ready) begin
            if (reg_sel_q == LAST_SEL) begin
              state_q      <= S_DONE;
              dump_valid_q <= 1'b0;
              done_q       <= 1'b1;
              reg_sel_q    <= '0;
            end else begin
              reg_sel_q <= reg_sel_q + 5'd1;
            end
          end
        end
        S_DONE: begin
          done_q       <= 1'b1;
          dump_valid_q <= 1'b0;
          reg_sel_q    <= '0;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  // The read port is combinational, so the beat data is the live read data while a beat is up.
  assign reg_sel     = reg_sel_q;
  assign dump_valid  = dump_valid_q;
  assign dump_idx    = reg_sel_q;
  assign dump_data   = dump_valid_q ? reg_data : '0;
  assign done        = done_q;
  assign done_cause  = done_cause_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: halt, timeout, cause priority, dump backpressure,
// mid-dump reset and stall/timeout depending on RUN_MONITOR_STALL_DETECT_EN.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_unknown;
  logic [31:0] reg_data;
  logic        dump_ready;
  logic [4:0]  reg_sel;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        done;
  logic [1:0]  done_cause;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] count;
  } term_t;

  beat_t beat_q[$];
  term_t term_q[$];

  cpu_run_monitor #(
    .XLEN(32), .NUM_REGS(8), .MAX_CYCLES(1000), .HALT_PC(32'h100), .STALL_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_unknown(pc_unknown),
    .reg_data(reg_data), .dump_ready(dump_ready), .reg_sel(reg_sel),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .done(done), .done_cause(done_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  assign reg_data = 32'(reg_sel) * 32'h11;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pc_valid   = 1'b0;
    pc_unknown = 1'b0;
    pc         = 32'h0;
    dump_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // mode 0: pc=4n, 1: pc=0x200+4n, 2: as 1 but halt+unknown at n=999, 3: pc fixed at 0x40
  task automatic run_phase(input int mode, input string tag);
    term_t exp;
    int n;
    n = 0;
    while (!dump_valid && n < 1100) begin
      pc_valid   = 1'b1;
      pc_unknown = 1'b0;
      case (mode)
        0: pc = 32'(4 * n);
        1: pc = 32'h200 + 32'(4 * n);
        2: begin
          pc         = (n == 999) ? 32'h100 : 32'h200 + 32'(4 * n);
          pc_unknown = (n == 999);
        end
        default: pc = 32'h40;
      endcase
      step();
      n++;
    end
    pc_valid   = 1'b0;
    pc_unknown = 1'b0;
    check({tag, " dump_entered"}, 64'(dump_valid), 64'd1);
    if (term_q.size() > 0) begin
      exp = term_q.pop_front();
      check({tag, " done_cause"}, 64'(done_cause), 64'(exp.cause));
      check({tag, " cycle_count"}, 64'(cycle_count), 64'(exp.count));
    end
    check({tag, " first_idx"}, 64'(dump_idx), 64'd0);
    check({tag, " done_low"}, 64'(done), 64'd0);
  endtask

  task automatic drain(input bit toggle, input string tag);
    beat_t b;
    int k;
    logic [4:0]  hidx;
    logic [31:0] hdata;
    bit held;
    for (int i = 0; i < 8; i++) beat_q.push_back('{5'(i), 32'(i) * 32'h11});
    k = 0;
    while (beat_q.size() > 0 && k < 64) begin
      dump_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (dump_valid && dump_ready) begin
        b = beat_q.pop_front();
        check({tag, " beat_idx"}, 64'(dump_idx), 64'(b.idx));
        check({tag, " beat_data"}, 64'(dump_data), 64'(b.data));
        check({tag, " beat_done_low"}, 64'(done), 64'd0);
      end
      held  = dump_valid && !dump_ready;
      hidx  = dump_idx;
      hdata = dump_data;
      step();
      if (held) begin
        check({tag, " hold_idx"}, 64'(dump_idx), 64'(hidx));
        check({tag, " hold_data"}, 64'(dump_data), 64'(hdata));
      end
      k++;
    end
    dump_ready = 1'b0;
    check({tag, " beats_left"}, 64'(beat_q.size()), 64'd0);
    beat_q.delete();
    check({tag, " done_after_last"}, 64'(done), 64'd1);
    check({tag, " valid_after_last"}, 64'(dump_valid), 64'd0);
    check({tag, " reg_sel_after_last"}, 64'(reg_sel), 64'd0);
  endtask

  initial begin
    int k;
    do_reset();
    check("rst done", 64'(done), 64'd0);
    check("rst dump_valid", 64'(dump_valid), 64'd0);
    check("rst cycle_count", 64'(cycle_count), 64'd0);
    check("rst done_cause", 64'(done_cause), 64'd0);
    check("rst reg_sel", 64'(reg_sel), 64'd0);
    check("rst dump_idx", 64'(dump_idx), 64'd0);
    check("rst dump_data", 64'(dump_data), 64'd0);

    term_q.push_back('{2'd1, 32'd65});
    run_phase(0, "halt");
    drain(1'b1, "halt");
    pc_valid   = 1'b1;
    pc_unknown = 1'b1;
    pc         = 32'h100;
    dump_ready = 1'b1;
    repeat (5) step();
    pc_valid   = 1'b0;
    pc_unknown = 1'b0;
    dump_ready = 1'b0;
    check("done sticky", 64'(done), 64'd1);
    check("done cause_held", 64'(done_cause), 64'd1);
    check("done count_held", 64'(cycle_count), 64'd65);
    check("done no_valid", 64'(dump_valid), 64'd0);

    do_reset();
    check("rst2 done", 64'(done), 64'd0);
    check("rst2 cycle_count", 64'(cycle_count), 64'd0);
    term_q.push_back('{2'd0, 32'd1000});
    run_phase(1, "timeout");
    drain(1'b0, "timeout");
    check("timeout count_held", 64'(cycle_count), 64'd1000);

    do_reset();
    term_q.push_back('{2'd2, 32'd1000});
    run_phase(2, "priority");
    dump_ready = 1'b1;
    k = 0;
    while (reg_sel != 5'd3 && k < 20) begin
      step();
      k++;
    end
    check("middump reg_sel", 64'(reg_sel), 64'd3);
    check("middump valid", 64'(dump_valid), 64'd1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    dump_ready = 1'b0;
    check("middump_rst valid", 64'(dump_valid), 64'd0);
    check("middump_rst done", 64'(done), 64'd0);
    check("middump_rst count", 64'(cycle_count), 64'd0);
    check("middump_rst reg_sel", 64'(reg_sel), 64'd0);
    check("middump_rst cause", 64'(done_cause), 64'd0);
    check("middump_rst data", 64'(dump_data), 64'd0);
    step();
    check("middump_rst running", 64'(cycle_count), 64'd1);

    do_reset();
`ifdef RUN_MONITOR_STALL_DETECT_EN
    term_q.push_back('{2'd3, 32'd17});
`else
    term_q.push_back('{2'd0, 32'd1000});
`endif
    run_phase(3, "stall");
    drain(1'b0, "stall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
